// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the writeback stage and its register file.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'd4;

  typedef enum logic {
    StRun,
    StHalted
  } wbState_t;

endpackage

// File: rtl/y86_regfile.sv
// 15x64 architectural register file: two write ports (M beats E on collision),
// three combinational read ports with no write bypass.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        weE,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic        weM,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM,
  input  logic [3:0]  srcA,
  output logic [63:0] valA,
  input  logic [3:0]  srcB,
  output logic [63:0] valB,
  input  logic [3:0]  srcDbg,
  output logic [63:0] valDbg
);

  logic [63:0] regs [0:14];

  // The M write is issued last so it overrides E when both target one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_RESET : 64'd0;
      end
    end else begin
      if (weE && dstE != RNONE) regs[dstE] <= valE;
      if (weM && dstM != RNONE) regs[dstM] <= valM;
    end
  end

  always_comb begin
    valA   = (srcA == RNONE) ? 64'd0 : regs[srcA];
    valB   = (srcB == RNONE) ? 64'd0 : regs[srcB];
    valDbg = (srcDbg == RNONE) ? 64'd0 : regs[srcDbg];
  end

endmodule

// File: rtl/writeback.sv
// Y86-64 writeback stage: commits W results to the register file, runs the
// run/halted status machine and keeps cycle and retirement counters.
module writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'd0,
  parameter int unsigned CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             W_stall,
  input  logic [1:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valE,
  input  logic [63:0]      W_valM,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      rf_valA,
  output logic [63:0]      rf_valB,
  input  logic [3:0]       dbg_rsel,
  output logic [63:0]      dbg_rval,
  output logic [1:0]       Stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  wbState_t         stateQ, stateD;
  logic [1:0]       statQ, statD;
  logic [CNT_W-1:0] cycleQ, cycleD;
  logic [CNT_W-1:0] retireQ, retireD;
  logic             advance;
  logic             commit;

  assign advance = (stateQ == StRun) && !W_stall;
  // Only AOK instructions write; a faulting mrmovq must leave dstM untouched.
  assign commit  = advance && (W_stat == SAOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= StRun;
      statQ   <= SAOK;
      cycleQ  <= '0;
      retireQ <= '0;
    end else begin
      stateQ  <= stateD;
      statQ   <= statD;
      cycleQ  <= cycleD;
      retireQ <= retireD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    statD   = statQ;
    cycleD  = cycleQ;
    retireD = retireQ;
    if (advance) begin
      cycleD = cycleQ + CNT_W'(1);
      if (W_stat != SAOK) begin
        stateD = StHalted;
        statD  = W_stat;
      end
      // A halt instruction retires; address/instruction faults do not.
      if ((W_stat == SAOK || W_stat == SHLT) && W_icode != INOP) begin
        retireD = retireQ + CNT_W'(1);
      end
    end
  end

  assign Stat       = statQ;
  assign halted     = (stateQ == StHalted);
  assign cycle_cnt  = cycleQ;
  assign retire_cnt = retireQ;

  y86_regfile #(
    .RSP_RESET(RSP_RESET)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .weE    (commit),
    .dstE   (W_dstE),
    .valE   (W_valE),
    .weM    (commit),
    .dstM   (W_dstM),
    .valM   (W_valM),
    .srcA   (d_srcA),
    .valA   (rf_valA),
    .srcB   (d_srcB),
    .valB   (rf_valB),
    .srcDbg (dbg_rsel),
    .valDbg (dbg_rval)
  );

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed vector table plus randomized run
// against a register-array reference model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        W_stall;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [3:0]  d_srcA, d_srcB, dbg_rsel;
  logic [63:0] rf_valA, rf_valB, dbg_rval;
  logic [1:0]  Stat;
  logic        halted;
  logic [63:0] cycle_cnt, retire_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback #(
    .RSP_RESET(64'd256),
    .CNT_W    (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .W_stall   (W_stall),
    .W_stat    (W_stat),
    .W_icode   (W_icode),
    .W_valE    (W_valE),
    .W_valM    (W_valM),
    .W_dstE    (W_dstE),
    .W_dstM    (W_dstM),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .rf_valA   (rf_valA),
    .rf_valB   (rf_valB),
    .dbg_rsel  (dbg_rsel),
    .dbg_rval  (dbg_rval),
    .Stat      (Stat),
    .halted    (halted),
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        rstBefore;
    logic        stall;
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  chkReg;
    logic [63:0] preVal;
    logic [63:0] postVal;
    logic [1:0]  expStat;
    logic        expHalted;
    logic [63:0] expCyc;
    logic [63:0] expRet;
  } vec_t;

  vec_t vecs [13];

  // Reference model state
  logic [63:0] mReg [15];
  logic        mHalted;
  logic [1:0]  mStat;
  logic [63:0] mCyc, mRet;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) mReg[i] = (i == 4) ? 64'd256 : 64'd0;
    mHalted = 1'b0;
    mStat   = 2'd0;
    mCyc    = 64'd0;
    mRet    = 64'd0;
  endtask

  task automatic modelStep();
    if (!mHalted && !W_stall) begin
      mCyc = mCyc + 64'd1;
      if (W_stat == 2'd0) begin
        if (W_dstE != 4'hF) mReg[W_dstE] = W_valE;
        if (W_dstM != 4'hF) mReg[W_dstM] = W_valM;
      end else begin
        mHalted = 1'b1;
        mStat   = W_stat;
      end
      if ((W_stat == 2'd0 || W_stat == 2'd1) && W_icode != 4'h1) mRet = mRet + 64'd1;
    end
  endtask

  function automatic logic [63:0] mRead(input logic [3:0] r);
    return (r == 4'hF) ? 64'd0 : mReg[r];
  endfunction

  initial begin
    rst = 1'b0; W_stall = 1'b0; W_stat = 2'd0; W_icode = 4'h1;
    W_valE = '0; W_valM = '0; W_dstE = 4'hF; W_dstM = 4'hF;
    d_srcA = 4'hF; d_srcB = 4'hF; dbg_rsel = 4'hF;

    //          rst  stl stat icode valE        valM        dstE  dstM  chk   pre        post       st  h  cyc ret
    vecs[0]  = '{1'b0, 0, 0, 4'h3, 64'h55,     64'h0,      4'h3, 4'hF, 4'h3, 64'h0,     64'h55,    0, 0, 1, 1};
    vecs[1]  = '{1'b0, 0, 0, 4'hB, 64'h108,    64'h77,     4'h4, 4'h4, 4'h4, 64'd256,   64'h77,    0, 0, 2, 2};
    vecs[2]  = '{1'b0, 0, 0, 4'hB, 64'h22,     64'h33,     4'h2, 4'h5, 4'h2, 64'h0,     64'h22,    0, 0, 3, 3};
    vecs[3]  = '{1'b0, 0, 0, 4'h1, 64'h0,      64'h0,      4'hF, 4'hF, 4'h5, 64'h33,    64'h33,    0, 0, 4, 3};
    vecs[4]  = '{1'b0, 1, 0, 4'h3, 64'h9,      64'h0,      4'h1, 4'hF, 4'h1, 64'h0,     64'h0,     0, 0, 4, 3};
    vecs[5]  = '{1'b0, 1, 0, 4'h3, 64'h9,      64'h0,      4'h1, 4'hF, 4'h1, 64'h0,     64'h0,     0, 0, 4, 3};
    vecs[6]  = '{1'b0, 1, 0, 4'h3, 64'h9,      64'h0,      4'h1, 4'hF, 4'h1, 64'h0,     64'h0,     0, 0, 4, 3};
    vecs[7]  = '{1'b0, 0, 0, 4'h3, 64'h9,      64'h0,      4'h1, 4'hF, 4'h1, 64'h0,     64'h9,     0, 0, 5, 4};
    vecs[8]  = '{1'b0, 0, 2, 4'h5, 64'h0,      64'hDEAD,   4'hF, 4'h6, 4'h6, 64'h0,     64'h0,     2, 1, 6, 4};
    vecs[9]  = '{1'b0, 0, 0, 4'h3, 64'h1,      64'h0,      4'h7, 4'hF, 4'h7, 64'h0,     64'h0,     2, 1, 6, 4};
    vecs[10] = '{1'b1, 0, 0, 4'h3, 64'hAB,     64'h0,      4'h8, 4'hF, 4'h8, 64'h0,     64'hAB,    0, 0, 1, 1};
    vecs[11] = '{1'b0, 0, 1, 4'h0, 64'h0,      64'h0,      4'hF, 4'hF, 4'h8, 64'hAB,    64'hAB,    1, 1, 2, 2};
    vecs[12] = '{1'b0, 0, 0, 4'h3, 64'h1,      64'h0,      4'h8, 4'hF, 4'h8, 64'hAB,    64'hAB,    1, 1, 2, 2};

    tick();
    pulseReset();
    chk("rst_rsp", dbg_rval, 64'h0);
    dbg_rsel = 4'd4; d_srcA = 4'd4; d_srcB = 4'd0; #1;
    chk("rst_rsp_dbg", dbg_rval, 64'd256);
    chk("rst_rsp_a", rf_valA, 64'd256);
    chk("rst_r0_b", rf_valB, 64'd0);
    chk("rst_stat", {62'd0, Stat}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);
    d_srcA = 4'hF; #1;
    chk("rnone_a", rf_valA, 64'd0);

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].rstBefore) pulseReset();
      W_stall = vecs[v].stall; W_stat = vecs[v].stat; W_icode = vecs[v].icode;
      W_valE = vecs[v].valE; W_valM = vecs[v].valM;
      W_dstE = vecs[v].dstE; W_dstM = vecs[v].dstM;
      d_srcA = vecs[v].chkReg;
      #1;
      chk($sformatf("v%0d_pre", v), rf_valA, vecs[v].preVal);
      tick();
      chk($sformatf("v%0d_post", v), rf_valA, vecs[v].postVal);
      chk($sformatf("v%0d_stat", v), {62'd0, Stat}, {62'd0, vecs[v].expStat});
      chk($sformatf("v%0d_halted", v), {63'd0, halted}, {63'd0, vecs[v].expHalted});
      chk($sformatf("v%0d_cycle", v), cycle_cnt, vecs[v].expCyc);
      chk($sformatf("v%0d_retire", v), retire_cnt, vecs[v].expRet);
    end

    // Reset while halted must restore every reset value, including the reg8 write.
    W_stall = 1'b1;
    pulseReset();
    chk("hrst_stat", {62'd0, Stat}, 64'd0);
    chk("hrst_halted", {63'd0, halted}, 64'd0);
    chk("hrst_cycle", cycle_cnt, 64'd0);
    chk("hrst_retire", retire_cnt, 64'd0);
    for (int r = 0; r < 16; r++) begin
      dbg_rsel = 4'(r); #1;
      chk($sformatf("hrst_reg%0d", r), dbg_rval, (r == 4) ? 64'd256 : 64'd0);
    end

    // Randomized run against the model; reads are checked before each edge.
    for (int c = 0; c < 600; c++) begin
      if ((mHalted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) pulseReset();
      W_stall = ($urandom_range(0, 4) == 0);
      W_stat  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_icode = 4'($urandom_range(0, 11));
      W_valE  = {$urandom, $urandom};
      W_valM  = {$urandom, $urandom};
      W_dstE  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      W_dstM  = ($urandom_range(0, 2) == 0) ? 4'hF : (($urandom_range(0, 3) == 0) ? W_dstE :
                4'($urandom_range(0, 14)));
      d_srcA   = 4'($urandom_range(0, 15));
      d_srcB   = 4'($urandom_range(0, 15));
      dbg_rsel = 4'($urandom_range(0, 15));
      #1;
      chk("rnd_a", rf_valA, mRead(d_srcA));
      chk("rnd_b", rf_valB, mRead(d_srcB));
      chk("rnd_dbg", dbg_rval, mRead(dbg_rsel));
      chk("rnd_stat", {62'd0, Stat}, {62'd0, mStat});
      chk("rnd_halted", {63'd0, halted}, {63'd0, mHalted});
      chk("rnd_cycle", cycle_cnt, mCyc);
      chk("rnd_retire", retire_cnt, mRet);
      tick();
      modelStep();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
